// File: rtl/eatup_pkg.sv
// Shared constants and state encoding for the EatUp collision and scoring stage.
package eatup_pkg;

  localparam int unsigned NUM_ENEMIES   = 3;
  localparam int unsigned ENEMY_R_DFLT  = 10;
  localparam logic [11:0] SCORE_MAX_BCD = 12'h999;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_DIFF    = 3'd2,
    S_SQUARE  = 3'd3,
    S_CMP     = 3'd4,
    S_DONE    = 3'd5
  } cs_state_e;

endpackage

// File: rtl/bcd_inc3.sv
// Combinational 3-digit BCD incrementer that saturates at 999 instead of wrapping.
module bcd_inc3
  import eatup_pkg::*;
(
  input  logic [11:0] value,
  output logic [11:0] value_inc
);

  // Ripple the carry digit by digit; assumes a valid BCD input
  always_comb begin
    value_inc = value;
    if (value == SCORE_MAX_BCD) begin
      value_inc = value;
    end else if (value[3:0] != 4'd9) begin
      value_inc = {value[11:4], value[3:0] + 4'd1};
    end else if (value[7:4] != 4'd9) begin
      value_inc = {value[11:8], value[7:4] + 4'd1, 4'd0};
    end else begin
      value_inc = {value[11:8] + 4'd1, 8'd0};
    end
  end

endmodule

// File: rtl/collision_score.sv
// Per-frame player/enemy collision scan with eat/grow pulses, latched game-over and BCD score.
module collision_score
  import eatup_pkg::*;
#(
  parameter int unsigned ENEMY_R = ENEMY_R_DFLT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        gamemenu,
  input  logic        gamerun,
  input  logic [9:0]  px,
  input  logic [9:0]  py,
  input  logic [5:0]  pr,
  input  logic [9:0]  e1x,
  input  logic [9:0]  e1y,
  input  logic [9:0]  e2x,
  input  logic [9:0]  e2y,
  input  logic [9:0]  e3x,
  input  logic [9:0]  e3y,
  output logic [2:0]  eat,
  output logic        grow,
  output logic        game_over,
  output logic [11:0] score,
  output logic        busy
);

  cs_state_e        state_r;
  logic [1:0]       idx_r;
  logic [9:0]       px_r, py_r;
  logic [5:0]       pr_r;
  logic [2:0][9:0]  ex_r, ey_r;
  logic [13:0]      thr_r;
  logic [9:0]       dx_r, dy_r;
  logic [20:0]      d2_r;

  logic [9:0]       ex_sel_s, ey_sel_s;
  logic [9:0]       dx_s, dy_s;
  logic [19:0]      sq_x_s, sq_y_s;
  logic [6:0]       rsum_s;
  logic [13:0]      thr_s;
  logic             hit_s, big_s;
  logic [11:0]      score_inc_s;

  // Select the enemy under test for the shared subtract/square datapath
  always_comb begin
    ex_sel_s = 10'd0;
    ey_sel_s = 10'd0;
    case (idx_r)
      2'd0: begin ex_sel_s = ex_r[0]; ey_sel_s = ey_r[0]; end
      2'd1: begin ex_sel_s = ex_r[1]; ey_sel_s = ey_r[1]; end
      2'd2: begin ex_sel_s = ex_r[2]; ey_sel_s = ey_r[2]; end
      default: begin ex_sel_s = 10'd0; ey_sel_s = 10'd0; end
    endcase
  end

  // Absolute differences, larger minus smaller so nothing wraps
  always_comb begin
    if (px_r >= ex_sel_s) dx_s = px_r - ex_sel_s;
    else                  dx_s = ex_sel_s - px_r;
    if (py_r >= ey_sel_s) dy_s = py_r - ey_sel_s;
    else                  dy_s = ey_sel_s - py_r;
  end

  assign sq_x_s = 20'(dx_r) * 20'(dx_r);
  assign sq_y_s = 20'(dy_r) * 20'(dy_r);
  assign rsum_s = {1'b0, pr} + 7'(ENEMY_R);
  assign thr_s  = 14'(rsum_s) * 14'(rsum_s);
  assign hit_s  = d2_r < {7'd0, thr_r};
  assign big_s  = pr_r > 6'(ENEMY_R);

  bcd_inc3 u_score_inc (
    .value     (score),
    .value_inc (score_inc_s)
  );

  // Scan sequencer; gamemenu overrides everything and clears the game
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= S_IDLE;
      idx_r     <= 2'd0;
      px_r      <= 10'd0;
      py_r      <= 10'd0;
      pr_r      <= 6'd0;
      ex_r      <= '0;
      ey_r      <= '0;
      thr_r     <= 14'd0;
      dx_r      <= 10'd0;
      dy_r      <= 10'd0;
      d2_r      <= 21'd0;
      eat       <= 3'b000;
      grow      <= 1'b0;
      game_over <= 1'b0;
      score     <= 12'h000;
      busy      <= 1'b0;
    end else begin
      eat  <= 3'b000;
      grow <= 1'b0;
      if (gamemenu) begin
        state_r   <= S_IDLE;
        idx_r     <= 2'd0;
        busy      <= 1'b0;
        score     <= 12'h000;
        game_over <= 1'b0;
      end else begin
        case (state_r)
          S_IDLE: begin
            if (frame_tick && gamerun && !game_over) begin
              state_r <= S_CAPTURE;
              busy    <= 1'b1;
            end else begin
              state_r <= S_IDLE;
              busy    <= 1'b0;
            end
          end
          S_CAPTURE: begin
            px_r    <= px;
            py_r    <= py;
            pr_r    <= pr;
            ex_r    <= {e3x, e2x, e1x};
            ey_r    <= {e3y, e2y, e1y};
            thr_r   <= thr_s;
            idx_r   <= 2'd0;
            state_r <= S_DIFF;
          end
          S_DIFF: begin
            dx_r    <= dx_s;
            dy_r    <= dy_s;
            state_r <= S_SQUARE;
          end
          S_SQUARE: begin
            d2_r    <= {1'b0, sq_x_s} + {1'b0, sq_y_s};
            state_r <= S_CMP;
          end
          S_CMP: begin
            if (hit_s && !big_s) begin
              game_over <= 1'b1;
              state_r   <= S_DONE;
            end else begin
              if (hit_s) begin
                eat[idx_r] <= 1'b1;
                grow       <= 1'b1;
                score      <= score_inc_s;
              end
              if (idx_r < 2'(NUM_ENEMIES - 1)) begin
                idx_r   <= idx_r + 2'd1;
                state_r <= S_DIFF;
              end else begin
                state_r <= S_DONE;
              end
            end
          end
          S_DONE: begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
          end
          default: begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_collision_score.sv
// Randomized and directed bench for collision_score against a cycle-timeline reference model.
module tb_collision_score;

  localparam int R = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        gamemenu = 1'b0;
  logic        gamerun = 1'b0;
  logic [9:0]  px = 10'd0, py = 10'd0;
  logic [5:0]  pr = 6'd0;
  logic [9:0]  ex_v [3];
  logic [9:0]  ey_v [3];
  logic [2:0]  eat;
  logic        grow, game_over, busy;
  logic [11:0] score;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_score = 0;
  bit exp_go    = 1'b0;

  always #20 clk = ~clk;

  collision_score #(.ENEMY_R(R)) dut (
    .clk(clk), .reset(rst_n), .frame_tick(frame_tick), .gamemenu(gamemenu), .gamerun(gamerun),
    .px(px), .py(py), .pr(pr),
    .e1x(ex_v[0]), .e1y(ey_v[0]), .e2x(ex_v[1]), .e2y(ey_v[1]), .e3x(ex_v[2]), .e3y(ey_v[2]),
    .eat(eat), .grow(grow), .game_over(game_over), .score(score), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  task automatic set_enemy(input int i, input int x, input int y);
    ex_v[i] = 10'(x);
    ey_v[i] = 10'(y);
  endtask

  // Fire one frame tick and check cycles T1..T13 against the model timeline.
  task automatic run_scan(input bit retick);
    logic [2:0] e_eat [14];
    bit         e_go [14];
    int         e_sc [14];
    bit         e_busy [14];
    int sc, last, d2, thr, t;
    bit started;
    sc = exp_score;
    last = 0;
    for (int c = 0; c < 14; c++) begin
      e_eat[c] = 3'b000; e_go[c] = exp_go; e_sc[c] = exp_score; e_busy[c] = 1'b0;
    end
    started = gamerun && !exp_go;
    if (started) begin
      last = 11;
      thr = (int'(pr) + R) * (int'(pr) + R);
      for (int i = 0; i < 3; i++) begin
        d2 = (int'(px) - int'(ex_v[i])) ** 2 + (int'(py) - int'(ey_v[i])) ** 2;
        t = 5 + 3 * i;
        if (d2 < thr) begin
          if (int'(pr) > R) begin
            e_eat[t][i] = 1'b1;
            sc = (sc < 999) ? sc + 1 : 999;
            for (int c = t; c < 14; c++) e_sc[c] = sc;
          end else begin
            for (int c = t; c < 14; c++) e_go[c] = 1'b1;
            last = t;
            break;
          end
        end
      end
      for (int c = 1; c <= last; c++) e_busy[c] = 1'b1;
      exp_score = sc;
      exp_go = e_go[13];
    end
    @(negedge clk);
    frame_tick = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      check_eq($sformatf("eat T%0d", c), 32'(eat), 32'(e_eat[c]));
      check_eq($sformatf("grow T%0d", c), 32'(grow), 32'(e_eat[c] != 3'b000));
      check_eq($sformatf("game_over T%0d", c), 32'(game_over), 32'(e_go[c]));
      check_eq($sformatf("score T%0d", c), 32'(score), 32'(to_bcd(e_sc[c])));
      check_eq($sformatf("busy T%0d", c), 32'(busy), 32'(e_busy[c]));
      if (c == 1) frame_tick = 1'b0;
      if (retick && c == 3) frame_tick = 1'b1;
      if (retick && c == 4) frame_tick = 1'b0;
    end
  endtask

  task automatic menu_pulse();
    @(negedge clk);
    gamemenu = 1'b1;
    @(negedge clk);
    gamemenu = 1'b0;
    exp_score = 0;
    exp_go = 1'b0;
    check_eq("menu score", 32'(score), 32'h0);
    check_eq("menu game_over", 32'(game_over), 32'h0);
    check_eq("menu busy", 32'(busy), 32'h0);
  endtask

  task automatic triple_eat_cfg();
    pr = 6'd30; px = 10'd300; py = 10'd300;
    for (int i = 0; i < 3; i++) set_enemy(i, 300 + i, 300);
  endtask

  task automatic abort_scan();
    int old_sc;
    bit old_go;
    old_sc = exp_score;
    old_go = exp_go;
    @(negedge clk);
    frame_tick = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      check_eq($sformatf("abort eat T%0d", c), 32'(eat), 32'h0);
      check_eq($sformatf("abort busy T%0d", c), 32'(busy), 32'(c <= 3));
      check_eq($sformatf("abort score T%0d", c), 32'(score), 32'(c <= 3 ? to_bcd(old_sc) : 12'h000));
      check_eq($sformatf("abort game_over T%0d", c), 32'(game_over), 32'(c <= 3 ? old_go : 1'b0));
      if (c == 1) frame_tick = 1'b0;
      if (c == 3) gamemenu = 1'b1;
      if (c == 4) gamemenu = 1'b0;
    end
    exp_score = 0;
    exp_go = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) set_enemy(i, 0, 0);
    gamerun = 1'b1;
    // Reset held with random ticks
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      frame_tick = 1'($urandom);
      check_eq("rst eat", 32'(eat), 32'h0);
      check_eq("rst grow", 32'(grow), 32'h0);
      check_eq("rst game_over", 32'(game_over), 32'h0);
      check_eq("rst score", 32'(score), 32'h0);
      check_eq("rst busy", 32'(busy), 32'h0);
    end
    frame_tick = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post-rst busy", 32'(busy), 32'h0);

    // Enemy 2 eaten
    pr = 6'd20; px = 10'd100; py = 10'd100;
    set_enemy(0, 500, 500); set_enemy(1, 120, 110); set_enemy(2, 800, 100);
    run_scan(1'b0);
    check_eq("eat e2 score", 32'(score), 32'h001);

    // Touching boundary is not a hit
    set_enemy(0, 130, 100); set_enemy(1, 600, 600);
    run_scan(1'b0);
    check_eq("touch score", 32'(score), 32'h001);

    // Equal radius is lethal; enemy 3 never evaluated; later ticks ignored
    pr = 6'd10;
    set_enemy(0, 100, 100); set_enemy(1, 700, 700); set_enemy(2, 105, 100);
    run_scan(1'b0);
    check_eq("lethal game_over", 32'(game_over), 32'h1);
    run_scan(1'b0);
    menu_pulse();

    // Re-tick during a scan is ignored
    pr = 6'd20;
    set_enemy(0, 500, 500); set_enemy(1, 120, 110); set_enemy(2, 800, 100);
    run_scan(1'b1);

    // Menu mid-scan aborts
    triple_eat_cfg();
    abort_scan();

    // Randomized scans
    for (int n = 0; n < 60; n++) begin
      pr = 6'($urandom_range(1, 63));
      px = 10'($urandom_range(100, 900));
      py = 10'($urandom_range(100, 900));
      for (int i = 0; i < 3; i++)
        set_enemy(i, int'(px) + $urandom_range(0, 160) - 80, int'(py) + $urandom_range(0, 160) - 80);
      gamerun = ($urandom_range(0, 7) != 0);
      run_scan(1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 9) == 0 || exp_go) menu_pulse();
    end
    gamerun = 1'b1;

    // BCD carry 099 -> 100
    menu_pulse();
    triple_eat_cfg();
    for (int n = 0; n < 33; n++) run_scan(1'b0);
    check_eq("score 099", 32'(score), 32'h099);
    set_enemy(1, 900, 900); set_enemy(2, 10, 900);
    run_scan(1'b0);
    check_eq("score carry 100", 32'(score), 32'h100);

    // Saturation at 999
    triple_eat_cfg();
    for (int n = 0; n < 300; n++) run_scan(1'b0);
    check_eq("score sat", 32'(score), 32'h999);
    run_scan(1'b0);
    check_eq("score stays 999", 32'(score), 32'h999);

    // Asynchronous reset mid-scan
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("pre-async busy", 32'(busy), 32'h1);
    #5 rst_n = 1'b0;
    #1;
    check_eq("async rst busy", 32'(busy), 32'h0);
    check_eq("async rst score", 32'(score), 32'h0);
    exp_score = 0;
    exp_go = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_scan(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
